// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Word widths, enable/reset levels, queue-entry layout and the FSM state encoding.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;
  localparam logic              RST_ENABLE   = 1'b1;
  localparam logic              BRANCH       = 1'b1;
  localparam int                FETCH_Q_DEPTH = 2;

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry {pc,inst} queue; head visible combinationally, writes land next cycle.
// keep_head_only trims to the oldest entry surviving this cycle's pop, admitting the push only if none survives.
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  fetch_entry_t            push_dat,
  input  logic                    pop,
  input  logic                    keep_head_only,
  output fetch_entry_t            head_dat,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW-1:0]   rd_ptr_nxt, wr_ptr_nxt, wr_idx;
  logic [CW-1:0]   count_nxt, count_after_pop;
  logic            wr_en;

  always_comb begin
    rd_ptr_nxt      = rd_ptr + PW'(pop);
    count_after_pop = count - CW'(pop);
    wr_en           = 1'b0;
    wr_idx          = wr_ptr;
    wr_ptr_nxt      = wr_ptr;
    count_nxt       = count;
    if (keep_head_only) begin
      if (count_after_pop != '0) begin
        // Oldest survivor stays; everything younger and this cycle's push are dropped.
        count_nxt  = CW'(1);
        wr_ptr_nxt = rd_ptr_nxt + PW'(1);
      end else begin
        wr_en      = push;
        wr_idx     = rd_ptr_nxt;
        wr_ptr_nxt = rd_ptr_nxt + PW'(push);
        count_nxt  = CW'(push);
      end
    end else begin
      wr_en      = push && ((count < FULL_CNT) || pop);
      wr_ptr_nxt = wr_ptr + PW'(wr_en);
      count_nxt  = count_after_pop + CW'(wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Fetch front end: owns PC, drives ROM, queues {pc,inst}; word fetched at t is at head at t+1.
// Stops fetching when the queue is full and ID is not popping; branches keep the delay slot and redirect PC.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = FETCH_Q_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic                   id_ready_i,
  output logic                   if_valid_o,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e           state, state_nxt;
  logic [INST_ADDR_W-1:0] pc, pc_nxt;
  logic [CW-1:0]          count;
  logic                   pop;
  logic                   branch_taken;
  fetch_entry_t           head_dat;
  fetch_entry_t           push_dat;

  assign if_valid_o   = (count != '0);
  assign pop          = if_valid_o & id_ready_i;
  assign branch_taken = (branch_flag_i == BRANCH);
  assign push_dat     = '{pc: pc, inst: rom_inst};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= ST_IDLE;
      pc    <= word_align(RESET_PC);
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rom_ce    = CHIP_DISABLE;
    rom_addr  = ZERO_WORD;
    pc_nxt    = pc;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if ((count < FULL_CNT) || pop) begin
          rom_ce   = CHIP_ENABLE;
          rom_addr = pc;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    // A redirect overrides the sequential increment, even if this cycle fetched.
    if (branch_taken) begin
      pc_nxt = word_align(branch_target_address_i);
    end else if (rom_ce == CHIP_ENABLE) begin
      pc_nxt = pc + 32'd4;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (rom_ce == CHIP_ENABLE),
    .push_dat       (push_dat),
    .pop            (pop),
    .keep_head_only (branch_taken),
    .head_dat       (head_dat),
    .count          (count)
  );

  assign if_pc_o   = if_valid_o ? head_dat.pc   : ZERO_WORD;
  assign if_inst_o = if_valid_o ? head_dat.inst : ZERO_WORD;

endmodule
